subtractor_serial: RTL and testbench

- Byte-serial multi-byte subtractor: diff = a - b - borrow_in over WIDTH bits, one byte per clock, LSB byte first.
- Reuses the existing combinational byte adder as its datapath: a + ~b + carry, with carry = ~borrow.
- Sits beside the ALU adder path and serves wide compares/subtracts where area matters more than latency.
- Valid/ready handshake on both the operand side and the result side.

---
 rtl/subtractor_serial_pkg.sv | 12 +
 rtl/subtractor_serial_adder_byte.sv | 18 +
 rtl/subtractor_serial.sv | 168 ++++++++++++++++
 tb/tb_subtractor_serial.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/subtractor_serial_pkg.sv
// Shared constants for the byte-serial subtractor: FSM encoding and datapath byte width.
package subtractor_serial_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

endpackage

// File: rtl/subtractor_serial_adder_byte.sv
// Plain 8-bit ripple adder with carry in/out; the subtractor feeds it an inverted subtrahend.
module adder_byte
   import subtractor_serial_pkg::*;
(
   input  logic [BYTE_W-1:0] x_i,
   input  logic [BYTE_W-1:0] y_i,
   input  logic              ci_i,
   output logic [BYTE_W-1:0] s_o,
   output logic              co_o
);

   logic [BYTE_W:0] sum9;

   assign sum9 = {1'b0, x_i} + {1'b0, y_i} + {{BYTE_W{1'b0}}, ci_i};
   assign s_o  = sum9[BYTE_W-1:0];
   assign co_o = sum9[BYTE_W];

endmodule

// File: rtl/subtractor_serial.sv
// Byte-serial WIDTH-bit subtractor (diff = a - b - borrow_in), LSB byte first, one byte per clock.
// Define SUB_FLAGS_EN to add the zero/negative/overflow result flags.
module subtractor_serial
   import subtractor_serial_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
`ifdef SUB_FLAGS_EN
   output logic             zero,
   output logic             negative,
   output logic             overflow,
`endif
   output logic             busy
);

   localparam int NBYTES = WIDTH / BYTE_W;
   localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

   state_e            state_q, state_d;
   logic [WIDTH-1:0]  a_q, a_d;
   logic [WIDTH-1:0]  b_q, b_d;
   logic [WIDTH-1:0]  diff_q, diff_d;
   logic [IDXW-1:0]   idx_q, idx_d;
   logic              carry_q, carry_d;
   logic              borrow_q, borrow_d;
`ifdef SUB_FLAGS_EN
   logic              zero_q, zero_d;
   logic              neg_q, neg_d;
   logic              ovf_q, ovf_d;
`endif

   logic [BYTE_W-1:0] byte_sum;
   logic              byte_co;
   logic              accept;
   logic              last_byte;

   // Operand registers shift right each RUN cycle, so the adder always sees byte 0.
   adder_byte u_adder (
      .x_i  (a_q[BYTE_W-1:0]),
      .y_i  (~b_q[BYTE_W-1:0]),
      .ci_i (carry_q),
      .s_o  (byte_sum),
      .co_o (byte_co)
   );

   assign accept    = (state_q == IDLE) && start_valid;
   assign last_byte = (state_q == RUN) && (idx_q == LAST_IDX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start_valid)  state_d = RUN;
         RUN:     if (last_byte)    state_d = DONE;
         DONE:    if (result_ready) state_d = IDLE;
         default:                   state_d = IDLE;
      endcase
   end

   always_comb begin
      start_ready  = 1'b0;
      result_valid = 1'b0;
      busy         = 1'b0;
      case (state_q)
         IDLE:    start_ready  = 1'b1;
         RUN:     busy         = 1'b1;
         DONE: begin
            result_valid = 1'b1;
            busy         = 1'b1;
         end
         default: start_ready  = 1'b0;
      endcase
   end

   always_comb begin
      a_d      = a_q;
      b_d      = b_q;
      diff_d   = diff_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      borrow_d = borrow_q;
`ifdef SUB_FLAGS_EN
      zero_d   = zero_q;
      neg_d    = neg_q;
      ovf_d    = ovf_q;
`endif
      if (accept) begin
         a_d     = a;
         b_d     = b;
         carry_d = ~borrow_in;
         idx_d   = '0;
`ifdef SUB_FLAGS_EN
         zero_d  = 1'b1;
`endif
      end else if (state_q == RUN) begin
         a_d = a_q >> BYTE_W;
         b_d = b_q >> BYTE_W;
         diff_d[int'(idx_q)*BYTE_W +: BYTE_W] = byte_sum;
         carry_d = byte_co;
         idx_d   = idx_q + 1'b1;
`ifdef SUB_FLAGS_EN
         zero_d  = zero_q & (byte_sum == '0);
`endif
         if (last_byte) begin
            borrow_d = ~byte_co;
`ifdef SUB_FLAGS_EN
            // On the last byte a_q/b_q hold the original MSB byte.
            neg_d = byte_sum[BYTE_W-1];
            ovf_d = (a_q[BYTE_W-1] != b_q[BYTE_W-1]) &&
                    (byte_sum[BYTE_W-1] != a_q[BYTE_W-1]);
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         borrow_q <= 1'b0;
`ifdef SUB_FLAGS_EN
         zero_q   <= 1'b0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         a_q      <= a_d;
         b_q      <= b_d;
         diff_q   <= diff_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         borrow_q <= borrow_d;
`ifdef SUB_FLAGS_EN
         zero_q   <= zero_d;
         neg_q    <= neg_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   assign diff       = diff_q;
   assign borrow_out = borrow_q;
`ifdef SUB_FLAGS_EN
   assign zero       = zero_q;
   assign negative   = neg_q;
   assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_subtractor_serial.sv
// Scoreboard bench: a 32-bit instance with directed vectors and an 8-bit instance swept against a model.
module tb_subtractor_serial;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] d;
      logic        bo;
      logic        z;
      logic        n;
      logic        v;
      int          acc;
   } exp_t;

   exp_t q32[$];
   exp_t q8[$];

   // 32-bit instance
   logic        start_valid = 1'b0, start_ready, borrow_in = 1'b0;
   logic [31:0] a = '0, b = '0, diff;
   logic        result_valid, result_ready = 1'b1, borrow_out, busy;
`ifdef SUB_FLAGS_EN
   logic        zero, negative, overflow;
`endif

   subtractor_serial #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .start_valid(start_valid), .start_ready(start_ready),
      .a(a), .b(b), .borrow_in(borrow_in),
      .result_valid(result_valid), .result_ready(result_ready),
      .diff(diff), .borrow_out(borrow_out),
`ifdef SUB_FLAGS_EN
      .zero(zero), .negative(negative), .overflow(overflow),
`endif
      .busy(busy)
   );

   // 8-bit instance
   logic       s8_start_valid = 1'b0, s8_start_ready, s8_borrow_in = 1'b0;
   logic [7:0] s8_a = '0, s8_b = '0, s8_diff;
   logic       s8_result_valid, s8_result_ready = 1'b1, s8_borrow_out, s8_busy;
`ifdef SUB_FLAGS_EN
   logic       s8_zero, s8_negative, s8_overflow;
`endif

   subtractor_serial #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n),
      .start_valid(s8_start_valid), .start_ready(s8_start_ready),
      .a(s8_a), .b(s8_b), .borrow_in(s8_borrow_in),
      .result_valid(s8_result_valid), .result_ready(s8_result_ready),
      .diff(s8_diff), .borrow_out(s8_borrow_out),
`ifdef SUB_FLAGS_EN
      .zero(s8_zero), .negative(s8_negative), .overflow(s8_overflow),
`endif
      .busy(s8_busy)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, expv, cyc);
      end
   endtask

   // Monitors: compare on every result handshake; latency checked on the first valid cycle.
   bit seen32 = 1'b0;
   always @(negedge clk) begin : mon32
      exp_t e;
      if (rst_n && result_valid) begin
         if (q32.size() == 0) begin
            chk("spurious_valid32", 32'd1, 32'd0);
         end else begin
            e = q32[0];
            if (!seen32) begin
               chk("latency32", 32'(cyc - e.acc), 32'd4);
               seen32 = 1'b1;
            end
            if (result_ready) begin
               e = q32.pop_front();
               seen32 = 1'b0;
               chk("diff32", diff, e.d);
               chk("borrow32", {31'd0, borrow_out}, {31'd0, e.bo});
`ifdef SUB_FLAGS_EN
               chk("zero32", {31'd0, zero}, {31'd0, e.z});
               chk("neg32", {31'd0, negative}, {31'd0, e.n});
               chk("ovf32", {31'd0, overflow}, {31'd0, e.v});
`endif
            end
         end
      end
   end

   bit seen8 = 1'b0;
   always @(negedge clk) begin : mon8
      exp_t e;
      if (rst_n && s8_result_valid) begin
         if (q8.size() == 0) begin
            chk("spurious_valid8", 32'd1, 32'd0);
         end else begin
            e = q8[0];
            if (!seen8) begin
               chk("latency8", 32'(cyc - e.acc), 32'd1);
               seen8 = 1'b1;
            end
            if (s8_result_ready) begin
               e = q8.pop_front();
               seen8 = 1'b0;
               chk("diff8", {24'd0, s8_diff}, e.d);
               chk("borrow8", {31'd0, s8_borrow_out}, {31'd0, e.bo});
`ifdef SUB_FLAGS_EN
               chk("zero8", {31'd0, s8_zero}, {31'd0, e.z});
               chk("neg8", {31'd0, s8_negative}, {31'd0, e.n});
               chk("ovf8", {31'd0, s8_overflow}, {31'd0, e.v});
`endif
            end
         end
      end
   end

   task automatic issue32(input logic [31:0] av, input logic [31:0] bv, input logic bi,
                          input logic [31:0] d, input logic bo,
                          input logic z, input logic n, input logic v);
      exp_t e;
      int   k = 0;
      @(negedge clk);
      while (!start_ready && k < 100) begin @(negedge clk); k++; end
      if (!start_ready) begin chk("accept_timeout32", 32'd0, 32'd1); return; end
      a = av; b = bv; borrow_in = bi; start_valid = 1'b1;
      e.d = d; e.bo = bo; e.z = z; e.n = n; e.v = v; e.acc = cyc + 1;
      q32.push_back(e);
      @(posedge clk); #1;
      start_valid = 1'b0;
      a = $urandom; b = $urandom; borrow_in = 1'($urandom);
   endtask

   task automatic issue8(input logic [7:0] av, input logic [7:0] bv, input logic bi);
      exp_t       e;
      logic [8:0] r;
      int         k = 0;
      @(negedge clk);
      while (!s8_start_ready && k < 100) begin @(negedge clk); k++; end
      if (!s8_start_ready) begin chk("accept_timeout8", 32'd0, 32'd1); return; end
      s8_a = av; s8_b = bv; s8_borrow_in = bi; s8_start_valid = 1'b1;
      r = {1'b0, av} - {1'b0, bv} - {8'd0, bi};
      e.d = {24'd0, r[7:0]}; e.bo = r[8];
      e.z = (r[7:0] == 8'd0); e.n = r[7];
      e.v = (av[7] != bv[7]) && (r[7] != av[7]);
      e.acc = cyc + 1;
      q8.push_back(e);
      @(posedge clk); #1;
      s8_start_valid = 1'b0;
      s8_a = 8'($urandom); s8_b = 8'($urandom); s8_borrow_in = 1'($urandom);
   endtask

   task automatic drain();
      int k = 0;
      while ((q32.size() != 0 || q8.size() != 0) && k < 200) begin @(negedge clk); k++; end
      chk("drain", 32'(q32.size() + q8.size()), 32'd0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not complete, errors so far %0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      int k;
      #12;
      chk("rst_start_ready", {31'd0, start_ready}, 32'd1);
      chk("rst_result_valid", {31'd0, result_valid}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_diff", diff, 32'd0);
      chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
      @(negedge clk); rst_n = 1'b1;

      //       a             b             bin  diff          bo  z  n  v
      issue32(32'h00000005, 32'h00000003, 1'b0, 32'h00000002, 0, 0, 0, 0);
      drain();
      issue32(32'h00000003, 32'h00000005, 1'b0, 32'hFFFFFFFE, 1, 0, 1, 0);
      issue32(32'h00000000, 32'h00000000, 1'b1, 32'hFFFFFFFF, 1, 0, 1, 0);
      issue32(32'h00000100, 32'h00000001, 1'b0, 32'h000000FF, 0, 0, 0, 0);
      issue32(32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 0, 0, 0, 1);
      issue32(32'h00001234, 32'h00001234, 1'b0, 32'h00000000, 0, 1, 0, 0);
      issue32(32'h12345678, 32'h12345679, 1'b0, 32'hFFFFFFFF, 1, 0, 1, 0);
      issue32(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1, 0, 1, 0);
      issue32(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1, 0, 1, 1);
      drain();

      // Backpressure: result must hold for 10 cycles while result_ready is low.
      @(posedge clk); #1 result_ready = 1'b0;
      issue32(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'h4B4B4B4B, 0, 0, 0, 1);
      k = 0;
      while (!result_valid && k < 20) begin @(negedge clk); k++; end
      chk("bp_valid_seen", {31'd0, result_valid}, 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, result_valid}, 32'd1);
         chk("bp_diff", diff, 32'h4B4B4B4B);
         chk("bp_borrow", {31'd0, borrow_out}, 32'd0);
         chk("bp_start_ready", {31'd0, start_ready}, 32'd0);
         chk("bp_busy", {31'd0, busy}, 32'd1);
      end
      @(posedge clk); #1 result_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_release_ready", {31'd0, start_ready}, 32'd1);
      chk("bp_release_valid", {31'd0, result_valid}, 32'd0);
      drain();

      // Reset two cycles after accept: pending result is dropped.
      issue32(32'h11111111, 32'h01010101, 1'b0, 32'h10101010, 0, 0, 0, 0);
      @(posedge clk); #2;
      rst_n = 1'b0;
      void'(q32.pop_back());
      #1;
      chk("midrst_valid", {31'd0, result_valid}, 32'd0);
      chk("midrst_start_ready", {31'd0, start_ready}, 32'd1);
      chk("midrst_diff", diff, 32'd0);
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      @(negedge clk); rst_n = 1'b1;
      issue32(32'h00010000, 32'h00000001, 1'b0, 32'h0000FFFF, 0, 0, 0, 0);
      drain();

      // 8-bit instance: sweep a/b over multiples of 17 (includes 0x00 and 0xFF) and both borrows.
      for (int ai = 0; ai < 16; ai++)
         for (int bi = 0; bi < 16; bi++)
            for (int ci = 0; ci < 2; ci++)
               issue8(8'(ai * 17), 8'(bi * 17 + ci * 3), 1'(ci));
      issue8(8'h80, 8'h01, 1'b0);
      issue8(8'h00, 8'hFF, 1'b1);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
